lock_sequencer: RTL and testbench
=================================

// Module: lock_sequencer
// PURPOSE
//  Initiator side of the seconds-countdown timer interface: issues timed-interval
//  requests (start pulse + 10-bit duration) and consumes the timer's done level.
//  Sequences a two-gate canal lock: valves, gates and chamber level, for up/down boat requests.
//  Sits between user request inputs and one shared countdown timer instance.
// PARAMETERS
//  FILL_SEC    420  fill-valve interval, seconds (10-bit, 1..1023)
//  DRAIN_SEC   480  drain-valve interval, seconds (10-bit, 1..1023)
//  DWELL_SEC   300  gate-open dwell interval, seconds (10-bit, 1..1023)
//  WDOG_CYCLES 2^20 max clk cycles in one wait phase (LOCK_WATCHDOG_EN only)
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high
//  req_up         in   1   boat at low side wants up; sampled each clk
//  req_down       in   1   boat at high side wants down; sampled each clk
//  tmr_done       in   1   timer level: 1 when timer count==0
//  tmr_start      out  1   one-cycle pulse: load tmr_seconds and begin countdown
//  tmr_seconds    out  10  duration presented with tmr_start; held until next start
//  fill_valve     out  1   1 = fill valve open
//  drain_valve    out  1   1 = drain valve open
//  gate_lo_open   out  1   1 = low-side gate open
//  gate_hi_open   out  1   1 = high-side gate open
//  level_high     out  1   chamber level: 1 high, 0 low
//  busy           out  1   1 whenever state != IDLE
//  fault          out  1   watchdog trip, sticky until reset
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (tmr_seconds=0, level_high=0); pending flags cleared.
//    Reset mid-sequence aborts immediately, with no further tmr_start.
//  - States: IDLE, DRAIN, GATE_LO, FILL, GATE_HI, FAULT; dir reg (UP/DOWN) set on leaving IDLE.
//  - Requests: req_up/req_down set pend_up/pend_down (level-sampled, duplicates collapse).
//    Pending flags persist while busy. In IDLE, pend_up has priority over pend_down.
//    Accepted flag clears on the IDLE-exit cycle; a request asserted on that same cycle is re-latched.
//  - UP sequence:   [DRAIN if level_high] -> GATE_LO -> FILL -> GATE_HI -> IDLE.
//  - DOWN sequence: [FILL if !level_high] -> GATE_HI -> DRAIN -> GATE_LO -> IDLE.
//  - FILL completion sets level_high=1; DRAIN completion sets level_high=0, same edge as exit.
//  - Actuator outputs are registered, one-hot, and equal the current state:
//    DRAIN->drain_valve, FILL->fill_valve, GATE_LO->gate_lo_open, GATE_HI->gate_hi_open.
//    Never more than one actuator is high. IDLE/FAULT: all actuators 0.
//  - Timer handshake, per timed state entry:
//    - Cycle E (first cycle in state): tmr_start=1, tmr_seconds=FILL/DRAIN/DWELL_SEC.
//    - Cycle E+1: arm cycle. tmr_done is ignored because the timer still shows its old count.
//    - From E+2: exit the state on the first cycle tmr_done==1.
//    - Next state is entered on the following edge; its tmr_start pulses in that cycle.
//  - Latency: a request sampled in IDLE at edge N gives state/actuator/tmr_start at edge N+1.
//    From the done-observed edge to the next actuator, latency is 1 cycle.
//  - tmr_start is never asserted on two consecutive cycles. Exactly one pulse per timed state.
//  - Wait phases have no timeout unless LOCK_WATCHDOG_EN.
// CONFIGURATION
//  LOCK_WATCHDOG_EN defined:
//    - 20-bit cycle counter, cleared on each state entry, counts in the wait state.
//    - Counter reaches WDOG_CYCLES -> FAULT: actuators 0, fault=1, no tmr_start.
//    - Requests are still latched but ignored. Only reset exits FAULT.
//  LOCK_WATCHDOG_EN undefined: no counter, fault tied 0, FAULT unreachable.
// TESTING (bench timer model; FILL_SEC=3, DRAIN_SEC=4, DWELL_SEC=2)
//  1. Reset, then req_up 1 cycle at level low -> GATE_LO(start,2) -> FILL(start,3) -> GATE_HI(start,2)
//     -> IDLE. level_high=1; exactly 3 tmr_start pulses.
//  2. level_high=1, req_down -> GATE_HI(2) -> DRAIN(4) -> GATE_LO(2) -> IDLE, level_high=0.
//     With level low, req_down first runs FILL(3).
//  3. req_up and req_down on the same cycle in IDLE -> UP sequence first.
//     DOWN sequence starts 1 cycle after UP returns to IDLE.
//  4. Timer done held at 1 during the arm cycle -> no early exit.
//     State lasts >= (seconds) timer ticks; actuators are one-hot every cycle.
//  5. Reset asserted during FILL -> next cycle all outputs 0, IDLE, level_high=0, pend cleared.
//  6. LOCK_WATCHDOG_EN, WDOG_CYCLES=16, tmr_done stuck 0 -> FAULT on cycle 16 of the wait.
//     fault=1; req_up is ignored until reset.

Source files
------------

// File: rtl/lock_sequencer.sv
// lock_sequencer
//   Sequences a two-gate canal lock (valves, gates, chamber level) for boats
//   going up or down. It is the initiator side of a shared seconds-countdown
//   timer: every timed state issues one tmr_start pulse with its duration and
//   then waits for the timer's done level.
//
// Ports
//   clk           in   1   system clock
//   reset         in   1   synchronous, active-high
//   req_up        in   1   boat on the low side wants to go up (level-sampled)
//   req_down      in   1   boat on the high side wants to go down (level-sampled)
//   tmr_done      in   1   timer level, 1 when the timer count is 0
//   tmr_start     out  1   one-cycle pulse: load tmr_seconds and start counting
//   tmr_seconds   out  10  duration presented with tmr_start, held until the next start
//   fill_valve    out  1   fill valve open
//   drain_valve   out  1   drain valve open
//   gate_lo_open  out  1   low-side gate open
//   gate_hi_open  out  1   high-side gate open
//   level_high    out  1   chamber level, 1 = high, 0 = low
//   busy          out  1   sequencer is not idle
//   fault         out  1   watchdog trip, sticky until reset
//
// Configuration
//   LOCK_WATCHDOG_EN  when defined, a 20-bit per-state cycle counter forces the
//                     FAULT state after WDOG_CYCLES cycles in one timed state.
//                     When undefined there is no counter and fault is tied 0.

module lock_sequencer #(
  parameter logic [9:0] FILL_SEC  = 10'd420,
  parameter logic [9:0] DRAIN_SEC = 10'd480,
  parameter logic [9:0] DWELL_SEC = 10'd300
`ifdef LOCK_WATCHDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES = 32'd1 << 20
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_up,
  input  logic       req_down,
  input  logic       tmr_done,
  output logic       tmr_start,
  output logic [9:0] tmr_seconds,
  output logic       fill_valve,
  output logic       drain_valve,
  output logic       gate_lo_open,
  output logic       gate_hi_open,
  output logic       level_high,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    GATE_LO,
    FILL,
    GATE_HI,
    FAULT
  } state_t;

  // Position inside a timed state: the start cycle, the arm cycle in which the
  // timer still shows its previous count, then the wait for done.
  typedef enum logic [1:0] {
    PH_ENTRY,
    PH_ARM,
    PH_WAIT
  } phase_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

  state_t state;
  state_t nxt;
  phase_t phase;
  dir_t   dir;
  dir_t   nxt_dir;
  logic   pend_up;
  logic   pend_down;
  logic   take_up;
  logic   take_down;
  logic   done_seen;
  logic   entering;
  logic   timed_nxt;

  function automatic logic is_timed(input state_t s);
    return (s == DRAIN) || (s == GATE_LO) || (s == FILL) || (s == GATE_HI);
  endfunction

  function automatic logic [9:0] secs_for(input state_t s);
    case (s)
      FILL:    return FILL_SEC;
      DRAIN:   return DRAIN_SEC;
      default: return DWELL_SEC;
    endcase
  endfunction

`ifdef LOCK_WATCHDOG_EN
  localparam logic [19:0] WDOG_LAST = 20'(WDOG_CYCLES - 32'd1);

  logic [19:0] wdog_cnt;
  logic        wdog_trip;

  // The trip fires on the edge where the count of cycles spent in the current
  // timed state reaches WDOG_CYCLES.
  assign wdog_trip = is_timed(state) && (wdog_cnt == WDOG_LAST);
`endif

  // Next-state decision. Both directions share the same chamber moves, so the
  // direction register only matters when leaving a gate state.
  always_comb begin
    nxt       = state;
    nxt_dir   = dir;
    take_up   = 1'b0;
    take_down = 1'b0;
    done_seen = (phase == PH_WAIT) && tmr_done;
    case (state)
      IDLE: begin
        if (pend_up) begin
          take_up = 1'b1;
          nxt_dir = DIR_UP;
          nxt     = level_high ? DRAIN : GATE_LO;
        end else if (pend_down) begin
          take_down = 1'b1;
          nxt_dir   = DIR_DOWN;
          nxt       = level_high ? GATE_HI : FILL;
        end
      end
      DRAIN: begin
        if (done_seen) nxt = GATE_LO;
      end
      FILL: begin
        if (done_seen) nxt = GATE_HI;
      end
      GATE_LO: begin
        if (done_seen) nxt = (dir == DIR_UP) ? FILL : IDLE;
      end
      GATE_HI: begin
        if (done_seen) nxt = (dir == DIR_UP) ? IDLE : DRAIN;
      end
      FAULT: begin
        nxt = FAULT;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
`ifdef LOCK_WATCHDOG_EN
    if (wdog_trip) nxt = FAULT;
`endif
  end

  assign entering  = (nxt != state);
  assign timed_nxt = is_timed(nxt);

  // Registered state and outputs. Outputs are computed from the next state so
  // actuators and the start pulse appear in the first cycle of each state.
  // Pending flags clear on the accepting edge but re-latch a request that is
  // still present on that same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      phase        <= PH_ENTRY;
      dir          <= DIR_UP;
      pend_up      <= 1'b0;
      pend_down    <= 1'b0;
      tmr_start    <= 1'b0;
      tmr_seconds  <= 10'd0;
      fill_valve   <= 1'b0;
      drain_valve  <= 1'b0;
      gate_lo_open <= 1'b0;
      gate_hi_open <= 1'b0;
      level_high   <= 1'b0;
      busy         <= 1'b0;
`ifdef LOCK_WATCHDOG_EN
      wdog_cnt     <= 20'd0;
      fault        <= 1'b0;
`endif
    end else begin
      state     <= nxt;
      dir       <= nxt_dir;
      pend_up   <= (pend_up & ~take_up) | req_up;
      pend_down <= (pend_down & ~take_down) | req_down;

      if (entering) begin
        phase <= PH_ENTRY;
      end else if (phase == PH_ENTRY) begin
        phase <= PH_ARM;
      end else if (phase == PH_ARM) begin
        phase <= PH_WAIT;
      end

      tmr_start <= entering && timed_nxt;
      if (entering && timed_nxt) begin
        tmr_seconds <= secs_for(nxt);
      end

      fill_valve   <= (nxt == FILL);
      drain_valve  <= (nxt == DRAIN);
      gate_lo_open <= (nxt == GATE_LO);
      gate_hi_open <= (nxt == GATE_HI);
      busy         <= (nxt != IDLE);

      // The chamber level flips on the same edge that completes the valve.
      if ((state == FILL) && (nxt == GATE_HI)) begin
        level_high <= 1'b1;
      end else if ((state == DRAIN) && (nxt == GATE_LO)) begin
        level_high <= 1'b0;
      end

`ifdef LOCK_WATCHDOG_EN
      if (entering) begin
        wdog_cnt <= 20'd0;
      end else if (is_timed(state)) begin
        wdog_cnt <= wdog_cnt + 20'd1;
      end
      fault <= fault | (nxt == FAULT);
`endif
    end
  end

`ifndef LOCK_WATCHDOG_EN
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer
//   Bench for lock_sequencer with a small countdown-timer model
//   (FILL_SEC=3, DRAIN_SEC=4, DWELL_SEC=2). A step-plan model predicts the
//   outputs every cycle; directed sequences pin the model with literal totals.

module tb_lock_sequencer;

  localparam int ST_IDLE  = 0;
  localparam int ST_DRAIN = 1;
  localparam int ST_LO    = 2;
  localparam int ST_FILL  = 3;
  localparam int ST_HI    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_up = 1'b0;
  logic       req_down = 1'b0;
  logic       tmr_done;
  logic       tmr_start;
  logic [9:0] tmr_seconds;
  logic       fill_valve;
  logic       drain_valve;
  logic       gate_lo_open;
  logic       gate_hi_open;
  logic       level_high;
  logic       busy;
  logic       fault;

  int checks = 0;
  int errors = 0;

  lock_sequencer #(
    .FILL_SEC(10'd3),
    .DRAIN_SEC(10'd4),
    .DWELL_SEC(10'd2)
`ifdef LOCK_WATCHDOG_EN
    ,
    .WDOG_CYCLES(16)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_up(req_up),
    .req_down(req_down),
    .tmr_done(tmr_done),
    .tmr_start(tmr_start),
    .tmr_seconds(tmr_seconds),
    .fill_valve(fill_valve),
    .drain_valve(drain_valve),
    .gate_lo_open(gate_lo_open),
    .gate_hi_open(gate_hi_open),
    .level_high(level_high),
    .busy(busy),
    .fault(fault)
  );

  always #5 clk = ~clk;

  // Countdown timer: one tick per clock, done is registered so it lags the
  // count by a cycle and still reads 1 during the arm cycle after a start.
  logic [9:0] tcount = 10'd0;
  logic       tdone_r = 1'b0;
  logic       stuck0 = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      tcount  <= 10'd0;
      tdone_r <= 1'b0;
    end else begin
      tdone_r <= (tcount == 10'd0);
      if (tmr_start) tcount <= tmr_seconds;
      else if (tcount != 10'd0) tcount <= tcount - 10'd1;
    end
  end

  assign tmr_done = stuck0 ? 1'b0 : tdone_r;

  // Step-plan model: a request expands into a list of chamber steps; each step
  // lasts its seconds plus three cycles (start, arm, registered done lag).
  int         m_plan[$];
  int         m_cur = ST_IDLE;
  int         m_left = 0;
  bit         m_start = 1'b0;
  bit         m_level = 1'b0;
  bit         m_pend_up = 1'b0;
  bit         m_pend_down = 1'b0;
  logic [9:0] m_secs = 10'd0;

  function automatic logic [9:0] secsOf(input int st);
    case (st)
      ST_FILL:  return 10'd3;
      ST_DRAIN: return 10'd4;
      default:  return 10'd2;
    endcase
  endfunction

  task modelEnterNext();
    if (m_plan.size() == 0) begin
      m_cur = ST_IDLE;
    end else begin
      m_cur   = m_plan.pop_front();
      m_secs  = secsOf(m_cur);
      m_left  = int'(m_secs) + 3;
      m_start = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    bit acc_up;
    bit acc_dn;
    acc_up  = 1'b0;
    acc_dn  = 1'b0;
    m_start = 1'b0;
    if (reset) begin
      m_plan.delete();
      m_cur       = ST_IDLE;
      m_left      = 0;
      m_level     = 1'b0;
      m_pend_up   = 1'b0;
      m_pend_down = 1'b0;
      m_secs      = 10'd0;
    end else begin
      if (m_cur == ST_IDLE) begin
        if (m_pend_up) begin
          acc_up = 1'b1;
          if (m_level) m_plan.push_back(ST_DRAIN);
          m_plan.push_back(ST_LO);
          m_plan.push_back(ST_FILL);
          m_plan.push_back(ST_HI);
          modelEnterNext();
        end else if (m_pend_down) begin
          acc_dn = 1'b1;
          if (!m_level) m_plan.push_back(ST_FILL);
          m_plan.push_back(ST_HI);
          m_plan.push_back(ST_DRAIN);
          m_plan.push_back(ST_LO);
          modelEnterNext();
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_cur == ST_FILL) m_level = 1'b1;
          else if (m_cur == ST_DRAIN) m_level = 1'b0;
          modelEnterNext();
        end
      end
      m_pend_up   = (m_pend_up && !acc_up) || (req_up === 1'b1);
      m_pend_down = (m_pend_down && !acc_dn) || (req_down === 1'b1);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic up, input logic down, input int cycles);
    @(negedge clk);
    req_up   = up;
    req_down = down;
    repeat (cycles) @(negedge clk);
    req_up   = 1'b0;
    req_down = 1'b0;
  endtask

  task automatic waitIdle(input int maxc, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((busy !== 1'b0) || (m_cur != ST_IDLE) || m_pend_up || m_pend_down) && (n < maxc));
    checkOutput({name, "_timeout"}, 32'(n < maxc), 1);
    repeat (2) @(negedge clk);
  endtask

  // Per-cycle comparison against the model, plus invariants on the actuators
  // and start pulse. Busy cycles and start pulses are tallied for the totals.
  bit   model_on = 1'b1;
  logic prev_start = 1'b0;
  int   busy_cycles = 0;
  int   start_count = 0;

  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("busy", busy, m_cur != ST_IDLE);
      checkOutput("fill_valve", fill_valve, m_cur == ST_FILL);
      checkOutput("drain_valve", drain_valve, m_cur == ST_DRAIN);
      checkOutput("gate_lo_open", gate_lo_open, m_cur == ST_LO);
      checkOutput("gate_hi_open", gate_hi_open, m_cur == ST_HI);
      checkOutput("level_high", level_high, m_level);
      checkOutput("tmr_start", tmr_start, m_start);
      checkOutput("tmr_seconds", tmr_seconds, m_secs);
      checkOutput("fault", fault, 0);
      checkOutput("one_hot", 32'($countones({fill_valve, drain_valve, gate_lo_open, gate_hi_open}) <= 1), 1);
      checkOutput("start_gap", prev_start & tmr_start, 0);
    end
    prev_start = tmr_start;
    if (busy === 1'b1) busy_cycles++;
    if (tmr_start === 1'b1) start_count++;
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int b0;
    int s0;
    int n;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_level", level_high, 0);
    checkOutput("reset_seconds", tmr_seconds, 0);
    checkOutput("reset_start", tmr_start, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] up from low level");
    b0 = busy_cycles;
    s0 = start_count;
    applyStimulus(1'b1, 1'b0, 1);
    waitIdle(200, "up_low");
    checkOutput("up_low_level", level_high, 1);
    checkOutput("up_low_starts", start_count - s0, 3);
    checkOutput("up_low_busy", busy_cycles - b0, 16);

    $display("[TB] down from high level");
    b0 = busy_cycles;
    s0 = start_count;
    applyStimulus(1'b0, 1'b1, 1);
    waitIdle(200, "down_high");
    checkOutput("down_high_level", level_high, 0);
    checkOutput("down_high_starts", start_count - s0, 3);
    checkOutput("down_high_busy", busy_cycles - b0, 17);

    $display("[TB] down from low level");
    b0 = busy_cycles;
    s0 = start_count;
    applyStimulus(1'b0, 1'b1, 1);
    waitIdle(200, "down_low");
    checkOutput("down_low_level", level_high, 0);
    checkOutput("down_low_starts", start_count - s0, 4);
    checkOutput("down_low_busy", busy_cycles - b0, 23);

    $display("[TB] simultaneous up and down");
    b0 = busy_cycles;
    s0 = start_count;
    applyStimulus(1'b1, 1'b1, 1);
    waitIdle(300, "both");
    checkOutput("both_level", level_high, 0);
    checkOutput("both_starts", start_count - s0, 6);
    checkOutput("both_busy", busy_cycles - b0, 33);

    $display("[TB] up held across the accepting edge");
    b0 = busy_cycles;
    s0 = start_count;
    applyStimulus(1'b1, 1'b0, 2);
    waitIdle(300, "relatch");
    checkOutput("relatch_level", level_high, 1);
    checkOutput("relatch_starts", start_count - s0, 7);
    checkOutput("relatch_busy", busy_cycles - b0, 39);

    $display("[TB] reset during fill");
    s0 = start_count;
    applyStimulus(1'b1, 1'b0, 1);
    n = 0;
    while ((fill_valve !== 1'b1) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fill_reached", 32'(n < 100), 1);
    applyStimulus(1'b0, 1'b1, 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_fill_valve", fill_valve, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_level", level_high, 0);
    checkOutput("rst_seconds", tmr_seconds, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("rst_pend_cleared", busy, 0);
    checkOutput("rst_starts", start_count - s0, 3);

`ifdef LOCK_WATCHDOG_EN
    $display("[TB] watchdog with done stuck low");
    model_on = 1'b0;
    stuck0   = 1'b1;
    applyStimulus(1'b1, 1'b0, 1);
    n = 0;
    while ((tmr_start !== 1'b1) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wd_start_seen", 32'(n < 20), 1);
    repeat (15) @(negedge clk);
    checkOutput("wd_not_yet", fault, 0);
    checkOutput("wd_gate_held", gate_lo_open, 1);
    @(negedge clk);
    checkOutput("wd_fault", fault, 1);
    checkOutput("wd_gate_closed", gate_lo_open, 0);
    checkOutput("wd_busy", busy, 1);
    s0 = start_count;
    applyStimulus(1'b1, 1'b0, 1);
    repeat (10) @(negedge clk);
    checkOutput("wd_sticky", fault, 1);
    checkOutput("wd_no_start", start_count - s0, 0);
    checkOutput("wd_actuators_off", {fill_valve, drain_valve, gate_lo_open, gate_hi_open}, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("wd_reset_clears", fault, 0);
    stuck0 = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
